// File: rtl/posit_fault_monitor_pkg.sv
// Shared definitions for the posit fault checker family: FSM state
// encoding, scale-error saturation value and lane-slice packing helper.
package posit_fault_monitor_pkg;

   typedef enum logic [1:0] {
      ST_TRUNC = 2'd0,
      ST_FULL  = 2'd1,
      ST_PROBE = 2'd2
   } mon_state_e;

   // Largest unsigned scale error representable in a w-bit field.
   function automatic int scale_err_sat(input int w);
      return (1 << w) - 1;
   endfunction

   // LSB position of lane 'lane' in a packed vector of w-bit lane fields.
   function automatic int lane_lsb(input int lane, input int w);
      return lane * w;
   endfunction

endpackage

// File: rtl/posit_scale_diff.sv
// Per-lane absolute scale difference |true - used| of two signed scales,
// computed at SCALE_W+1 bits and saturated back to SCALE_W bits.
module posit_scale_diff
   import posit_fault_monitor_pkg::*;
#(
   parameter int SCALE_W = 7
) (
   input  logic [SCALE_W-1:0] i_true_scale,
   input  logic [SCALE_W-1:0] i_used_scale,
   output logic [SCALE_W-1:0] o_abs_err
);

   localparam logic [SCALE_W-1:0] LP_SAT = SCALE_W'(scale_err_sat(SCALE_W));

   logic signed [SCALE_W:0] w_true_ext;
   logic signed [SCALE_W:0] w_used_ext;
   logic signed [SCALE_W:0] w_diff;
   logic        [SCALE_W:0] w_abs;

   assign w_true_ext = {i_true_scale[SCALE_W-1], i_true_scale};
   assign w_used_ext = {i_used_scale[SCALE_W-1], i_used_scale};
   assign w_diff     = w_true_ext - w_used_ext;
   assign w_abs      = w_diff[SCALE_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
   // Anything that does not fit SCALE_W bits clamps to the all-ones value.
   assign o_abs_err  = w_abs[SCALE_W] ? LP_SAT : w_abs[SCALE_W-1:0];

endmodule

// File: rtl/posit_fault_monitor.sv
// Multi-lane posit fault monitor: registered output stage, per-beat max
// scale error, and an adaptive-precision FSM (TRUNC -> FULL -> PROBE).
// Handshake: a beat moves on a port when valid && ready are both high in
// the same cycle; valid never depends on ready, ready = !out_valid || out_ready.
// Optional statistics (fault_count, max_scale_err) exist only when the
// macro POSIT_FAULT_MON_STATS_EN is defined; otherwise both read as 0.
module posit_fault_monitor
   import posit_fault_monitor_pkg::*;
#(
   parameter  int NLANES       = 4,
   parameter  int SCALE_W      = 7,
   parameter  int WINDOW       = 16,
   parameter  int FAULT_THRESH = 2,
   parameter  int HOLD_BEATS   = 32,
   parameter  int CNT_W        = 16,
   localparam int WC_W         = $clog2(WINDOW),
   localparam int HC_W         = (HOLD_BEATS > 1) ? $clog2(HOLD_BEATS) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NLANES-1:0]         in_fault,
   input  logic [NLANES*SCALE_W-1:0] in_true_scale,
   input  logic [NLANES*SCALE_W-1:0] in_used_scale,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NLANES-1:0]         out_fault_mask,
   output logic [SCALE_W-1:0]        out_scale_err,
   output logic                      mode_full,
   output logic                      probing,
   output logic [CNT_W-1:0]          fault_count,
   output logic [SCALE_W-1:0]        max_scale_err,
   output logic [1:0]                dbg_state,
   output logic [WC_W-1:0]           dbg_win_cnt,
   output logic [HC_W-1:0]           dbg_hold_cnt
);

   localparam int NF_W  = $clog2(NLANES + 1);
   localparam int WF_W  = $clog2(FAULT_THRESH + 1);
   localparam int SUM_W = ((WF_W > NF_W) ? WF_W : NF_W) + 1;
   localparam int FC_W  = CNT_W + 1;

   localparam logic [WC_W-1:0] LP_WIN_LAST  = WC_W'(WINDOW - 1);
   localparam logic [HC_W-1:0] LP_HOLD_LAST = HC_W'(HOLD_BEATS - 1);

   mon_state_e        r_state, w_state_nxt;
   logic [WC_W-1:0]   r_win_cnt, w_win_cnt_nxt;
   logic [WF_W-1:0]   r_win_faults, w_win_faults_nxt;
   logic [HC_W-1:0]   r_hold_cnt, w_hold_cnt_nxt;

   logic                 r_out_valid;
   logic [NLANES-1:0]    r_out_mask;
   logic [SCALE_W-1:0]   r_out_err;

   logic                 w_accept;
   logic [NF_W-1:0]      w_nf;
   logic [SUM_W-1:0]     w_sum;
   logic                 w_thresh_hit;
   logic [WF_W-1:0]      w_flt_sat;
   logic [SCALE_W-1:0]   w_lane_err [NLANES];
   logic [SCALE_W-1:0]   w_beat_err;

   assign in_ready = !r_out_valid || out_ready;
   assign w_accept = in_valid && in_ready;

   for (genvar g = 0; g < NLANES; g++) begin : g_lane
      posit_scale_diff #(.SCALE_W(SCALE_W)) u_diff (
         .i_true_scale (in_true_scale[lane_lsb(g, SCALE_W) +: SCALE_W]),
         .i_used_scale (in_used_scale[lane_lsb(g, SCALE_W) +: SCALE_W]),
         .o_abs_err    (w_lane_err[g])
      );
   end

   // Per-beat maximum of the lane scale errors.
   always_comb begin
      w_beat_err = '0;
      for (int i = 0; i < NLANES; i++) begin
         if (w_lane_err[i] > w_beat_err) w_beat_err = w_lane_err[i];
      end
   end

   // Number of faulting lanes in the current input beat.
   always_comb begin
      w_nf = '0;
      for (int i = 0; i < NLANES; i++) begin
         w_nf = w_nf + NF_W'(in_fault[i]);
      end
   end

   assign w_sum        = SUM_W'(r_win_faults) + SUM_W'(w_nf);
   assign w_thresh_hit = (w_sum >= SUM_W'(FAULT_THRESH));
   assign w_flt_sat    = w_thresh_hit ? WF_W'(FAULT_THRESH) : WF_W'(w_sum);

   // Output stage: load on accept, drain when downstream takes the beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_mask  <= '0;
         r_out_err   <= '0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_mask  <= in_fault;
         r_out_err   <= w_beat_err;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // FSM and window/hold counters state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_TRUNC;
         r_win_cnt    <= '0;
         r_win_faults <= '0;
         r_hold_cnt   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_win_cnt    <= w_win_cnt_nxt;
         r_win_faults <= w_win_faults_nxt;
         r_hold_cnt   <= w_hold_cnt_nxt;
      end
   end

   // Next-state logic; only accepted beats (or clear) move anything.
   always_comb begin
      w_state_nxt      = r_state;
      w_win_cnt_nxt    = r_win_cnt;
      w_win_faults_nxt = r_win_faults;
      w_hold_cnt_nxt   = r_hold_cnt;
      if (clear) begin
         w_state_nxt      = ST_TRUNC;
         w_win_cnt_nxt    = '0;
         w_win_faults_nxt = '0;
         w_hold_cnt_nxt   = '0;
      end else if (w_accept) begin
         case (r_state)
            ST_TRUNC: begin
               // Threshold crossing beats window completion.
               if (w_thresh_hit) begin
                  w_state_nxt      = ST_FULL;
                  w_win_cnt_nxt    = '0;
                  w_win_faults_nxt = '0;
                  w_hold_cnt_nxt   = '0;
               end else if (r_win_cnt == LP_WIN_LAST) begin
                  w_win_cnt_nxt    = '0;
                  w_win_faults_nxt = '0;
               end else begin
                  w_win_cnt_nxt    = r_win_cnt + WC_W'(1);
                  w_win_faults_nxt = w_flt_sat;
               end
            end
            ST_FULL: begin
               if (r_hold_cnt == LP_HOLD_LAST) begin
                  w_state_nxt      = ST_PROBE;
                  w_win_cnt_nxt    = '0;
                  w_win_faults_nxt = '0;
                  w_hold_cnt_nxt   = '0;
               end else begin
                  w_hold_cnt_nxt   = r_hold_cnt + HC_W'(1);
               end
            end
            ST_PROBE: begin
               if (w_nf != '0) begin
                  w_state_nxt      = ST_FULL;
                  w_win_cnt_nxt    = '0;
                  w_win_faults_nxt = '0;
                  w_hold_cnt_nxt   = '0;
               end else if (r_win_cnt == LP_WIN_LAST) begin
                  w_state_nxt      = ST_TRUNC;
                  w_win_cnt_nxt    = '0;
                  w_win_faults_nxt = '0;
               end else begin
                  w_win_cnt_nxt    = r_win_cnt + WC_W'(1);
               end
            end
            default: begin
               w_state_nxt      = ST_TRUNC;
               w_win_cnt_nxt    = '0;
               w_win_faults_nxt = '0;
               w_hold_cnt_nxt   = '0;
            end
         endcase
      end
   end

`ifdef POSIT_FAULT_MON_STATS_EN
   logic [CNT_W-1:0]   r_fault_count;
   logic [SCALE_W-1:0] r_max_err;
   logic [FC_W-1:0]    w_fc_sum;

   assign w_fc_sum = {1'b0, r_fault_count} + FC_W'(w_nf);

   // Saturating fault total and running maximum scale error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fault_count <= '0;
         r_max_err     <= '0;
      end else if (clear) begin
         r_fault_count <= '0;
         r_max_err     <= '0;
      end else if (w_accept) begin
         r_fault_count <= w_fc_sum[CNT_W] ? '1 : w_fc_sum[CNT_W-1:0];
         if (w_beat_err > r_max_err) r_max_err <= w_beat_err;
      end
   end

   assign fault_count   = r_fault_count;
   assign max_scale_err = r_max_err;
`else
   assign fault_count   = '0;
   assign max_scale_err = '0;
`endif

   assign out_valid      = r_out_valid;
   assign out_fault_mask = r_out_mask;
   assign out_scale_err  = r_out_err;
   assign mode_full      = (r_state == ST_FULL);
   assign probing        = (r_state == ST_PROBE);
   assign dbg_state      = r_state;
   assign dbg_win_cnt    = r_win_cnt;
   assign dbg_hold_cnt   = r_hold_cnt;

endmodule
